// File: rtl/alu_sequencer.sv
// Multi-cycle command front end for the 8-bit combinational ALU: repeats one op N times with the
// result fed back into A. The optional zero flag on the response is enabled by ALU_SEQ_ZERO_FLAG_EN.
module alu_sequencer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // Valid and its payload stay stable until that edge. Ready never depends on valid.
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [3:0]       alu_op,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   input  logic [7:0]       alu_out,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_carry,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic             rsp_zero,
`endif
   output logic [1:0]       dbg_state
);

   localparam logic [3:0] OP_A_IS_ZERO = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       acc;
   logic [7:0]       b_reg;
   logic [3:0]       op_reg;
   logic [CNT_W-1:0] remaining;
   logic             carry_reg;

   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = 8'h00;
      rsp_carry = 1'b0;
      alu_op    = 4'd0;
      alu_a     = 8'h00;
      alu_b     = 8'h00;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = EXEC;
         end
         EXEC: begin
            alu_op = op_reg;
            alu_a  = acc;
            alu_b  = b_reg;
            if (remaining == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = acc;
            rsp_carry = carry_reg;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= 8'h00;
         b_reg     <= 8'h00;
         op_reg    <= 4'd0;
         remaining <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  acc       <= cmd_a;
                  b_reg     <= cmd_b;
                  op_reg    <= cmd_op;
                  remaining <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                  carry_reg <= 1'b0;
               end
            end
            EXEC: begin
               // The zero test reports through the carry and leaves the accumulator intact.
               if (op_reg == OP_A_IS_ZERO) carry_reg <= alu_carry;
               else                        acc       <= alu_out;
               remaining <= remaining - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign rsp_zero = (state_q == RESP) && (acc == 8'h00);
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural stand-in for the combinational ALU.
module tb_alu_sequencer;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [7:0]       cmd_a;
   logic [7:0]       cmd_b;
   logic [CNT_W-1:0] cmd_count;
   logic [3:0]       alu_op;
   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   logic [7:0]       alu_out;
   logic             alu_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;
   logic             rsp_carry;
   logic             rsp_zero;
   logic [1:0]       dbg_state;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_count (cmd_count),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
`ifdef ALU_SEQ_ZERO_FLAG_EN
      .rsp_zero  (rsp_zero),
`endif
      .dbg_state (dbg_state)
   );

`ifndef ALU_SEQ_ZERO_FLAG_EN
   assign rsp_zero = 1'b0;
`endif

   // ALU stand-in; ADD and SUB raise a carry so that a leak into rsp_carry is visible.
   always_comb begin
      logic [8:0] wide;
      wide      = 9'd0;
      alu_out   = 8'h00;
      alu_carry = 1'b0;
      case (alu_op)
         4'd0:  alu_out = alu_a;
         4'd1:  alu_out = alu_a << 1;
         4'd2:  alu_out = alu_a >> 1;
         4'd3:  alu_out = (alu_a < alu_b) ? alu_a : alu_b;
         4'd4:  alu_out = alu_a << alu_b[2:0];
         4'd5:  begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = wide[7:0]; alu_carry = wide[8]; end
         4'd6:  alu_carry = (alu_a == 8'h00);
         4'd7:  alu_out = alu_b;
         4'd8:  alu_out = alu_a + 8'd1;
         4'd9:  alu_out = alu_a - 8'd1;
         4'd10: alu_out = 8'h00;
         4'd11: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = wide[7:0]; alu_carry = wide[8]; end
         default: alu_out = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Presents a command at a negedge, checks it is accepted, and measures cycles to rsp_valid.
   task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [CNT_W-1:0] cnt, input int exp_lat);
      int lat;
      @(negedge clk);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_count = cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
   endtask

   // Called at a negedge where rsp_valid should be 1: checks the payload, completes the handshake.
   task automatic take_rsp(input string tag, input logic [7:0] exp_data, input logic exp_carry);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rsp_data"}, rsp_data, exp_data);
      chk({tag, "_rsp_carry"}, rsp_carry, exp_carry);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk({tag, "_rsp_zero"}, rsp_zero, (exp_data == 8'h00));
`endif
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_back_idle"}, cmd_ready, 1'b1);
      chk({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_count = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_rsp_carry", rsp_carry, 1'b0);
      chk("rst_rsp_zero", rsp_zero, 1'b0);
      chk("rst_alu_bus", {alu_op, alu_a, alu_b}, 20'h0);
      chk("rst_state", dbg_state, 2'd0);

      // Reset during the 3rd EXEC cycle of an 8-step shift.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'h01; cmd_b = 8'h00; cmd_count = 4'd8;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_alu_op", alu_op, 4'd1);
      chk("mid_alu_a", alu_a, 8'h04);
      chk("mid_cmd_ready", cmd_ready, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_alu_op", alu_op, 4'd0);
      chk("mid_rst_alu_a", alu_a, 8'h00);
      issue("inc", 4'd8, 8'h05, 8'h00, 4'd1, 2);
      take_rsp("inc", 8'h06, 1'b0);

      issue("add3", 4'd5, 8'h10, 8'h30, 4'd3, 4);
      take_rsp("add3", 8'hA0, 1'b0);
      issue("add_wrap", 4'd5, 8'hF0, 8'h20, 4'd1, 2);
      take_rsp("add_wrap", 8'h10, 1'b0);

      issue("zt0", 4'd6, 8'h00, 8'h00, 4'd1, 2);
      take_rsp("zt0", 8'h00, 1'b1);
      // rsp_ready held high across the whole command must not shorten it.
      rsp_ready = 1'b1;
      issue("zt7", 4'd6, 8'h07, 8'h00, 4'd2, 3);
      take_rsp("zt7", 8'h07, 1'b0);

      issue("dec_cnt0", 4'd9, 8'h00, 8'h00, 4'd0, 2);
      take_rsp("dec_cnt0", 8'hFF, 1'b0);

      issue("sub_bp", 4'd11, 8'h50, 8'h10, 4'd2, 3);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_data", rsp_data, 8'h30);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         @(negedge clk);
      end
      take_rsp("sub_bp", 8'h30, 1'b0);

      issue("illegal", 4'd13, 8'h55, 8'h00, 4'd2, 3);
      take_rsp("illegal", 8'h00, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
